// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive deserializer.
// Optional macro PARITY_CHK_EN adds the PARITY framing state.
package uart_pkg;

   localparam bit LSB_FIRST_C = 1'b1;
   localparam bit MSB_FIRST_C = 1'b0;

`ifdef PARITY_CHK_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } sipo_state_e;
`else
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } sipo_state_e;
`endif

   // Bit-counter width able to hold the value data_w.
   function automatic int unsigned cnt_w(input int unsigned data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Parametrised width/direction shift register with enable and clear.
// word_nxt is the register's next value, i.e. it already includes a bit
// being shifted in this cycle.
module sipo_shift_core
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter bit          LSB_FIRST = LSB_FIRST_C
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              clr,
   input  logic              en,
   input  logic              din,
   output logic [DATA_W-1:0] word_nxt
);

   logic [DATA_W-1:0] sreg_q;
   logic [DATA_W-1:0] sreg_d;

   // Next shift-register value: clear wins, then shift in bit order.
   always_comb begin
      sreg_d = sreg_q;
      if (clr) begin
         sreg_d = '0;
      end else if (en) begin
         if (LSB_FIRST) sreg_d = {din, sreg_q[DATA_W-1:1]};
         else           sreg_d = {sreg_q[DATA_W-2:0], din};
      end
   end

   // Shift-register state.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) sreg_q <= '0;
      else         sreg_q <= sreg_d;
   end

   assign word_nxt = sreg_d;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer for the UART receive path.
// Framing FSM, bit counter and registered word output with valid pulse.
// Optional macro PARITY_CHK_EN: adds a parity bit after the data bits
// and the parity_err output.
module sipo_deserializer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter bit          LSB_FIRST  = LSB_FIRST_C,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      start,
   input  logic                      clear,
   input  logic                      shift_en,
   input  logic                      rx_in,
   output logic [DATA_W-1:0]         data,
   output logic                      data_valid,
   output logic                      busy,
   output logic [cnt_w(DATA_W)-1:0]  bit_cnt
`ifdef PARITY_CHK_EN
   ,
   output logic                      parity_err
`endif
);

   localparam int unsigned CNT_W = cnt_w(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   sipo_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              core_clr, core_en;
   logic [DATA_W-1:0] word_nxt;
`ifdef PARITY_CHK_EN
   logic              perr_q, perr_d;
`else
   logic              unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD;
`endif

   sipo_shift_core #(
      .DATA_W    (DATA_W),
      .LSB_FIRST (LSB_FIRST)
   ) u_core (
      .clk      (clk),
      .arst_n   (arst_n),
      .clr      (core_clr),
      .en       (core_en),
      .din      (rx_in),
      .word_nxt (word_nxt)
   );

   // Next-state logic: clear beats start, start beats any shift.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      core_clr = 1'b0;
      core_en  = 1'b0;
`ifdef PARITY_CHK_EN
      perr_d   = perr_q;
`endif
      if (clear) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         core_clr = 1'b1;
      end else if (start) begin
         state_d  = ST_SHIFT;
         cnt_d    = '0;
         core_clr = 1'b1;
      end else begin
         case (state_q)
            ST_SHIFT: begin
               if (shift_en) begin
                  core_en = 1'b1;
                  if (cnt_q == CNT_LAST) begin
`ifdef PARITY_CHK_EN
                     state_d = ST_PARITY;
                     cnt_d   = cnt_q + CNT_W'(1);
`else
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                     data_d  = word_nxt;
                     valid_d = 1'b1;
`endif
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
`ifdef PARITY_CHK_EN
            ST_PARITY: begin
               // Core is idle here, so word_nxt holds the completed word.
               if (shift_en) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  data_d  = word_nxt;
                  valid_d = 1'b1;
                  perr_d  = (^word_nxt) ^ rx_in ^ PARITY_ODD;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // FSM, counter and output registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
`ifdef PARITY_CHK_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
`ifdef PARITY_CHK_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign busy       = (state_q != ST_IDLE);
   assign bit_cnt    = cnt_q;
`ifdef PARITY_CHK_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Testbench: three deserializer instances (8-bit LSB-first, 8-bit
// MSB-first, 5-bit LSB-first) share one stimulus stream; each is checked
// every cycle against a frame-level reference model.
module tb_sipo_deserializer;

   localparam bit P_ODD = 1'b0;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic start = 1'b0, clear = 1'b0, shift_en = 1'b0, rx_in = 1'b0;

   logic [7:0] data_l8, data_m8;
   logic [4:0] data_l5;
   logic [3:0] cnt_l8, cnt_m8;
   logic [2:0] cnt_l5;
   logic [2:0] valid, busy;
`ifdef PARITY_CHK_EN
   logic [2:0] perr;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int vcount_l8 = 0;

   // Reference model state per instance.
   int          mw   [3] = '{8, 8, 5};
   bit          mlsb [3] = '{1'b1, 1'b0, 1'b1};
   int          mst  [3];           // 0 idle, 1 data bits, 2 awaiting parity
   int          mn   [3];
   bit          mbits[3][16];
   logic [15:0] mdata[3];
   bit          mvalid[3];
   bit          mperr[3];
   bit          prev_valid[3];

   always #5 clk = ~clk;

   sipo_deserializer #(.DATA_W(8), .LSB_FIRST(1'b1), .PARITY_ODD(P_ODD)) u_l8 (
      .clk(clk), .arst_n(arst_n), .start(start), .clear(clear), .shift_en(shift_en),
      .rx_in(rx_in), .data(data_l8), .data_valid(valid[0]), .busy(busy[0]), .bit_cnt(cnt_l8)
`ifdef PARITY_CHK_EN
      , .parity_err(perr[0])
`endif
   );
   sipo_deserializer #(.DATA_W(8), .LSB_FIRST(1'b0), .PARITY_ODD(P_ODD)) u_m8 (
      .clk(clk), .arst_n(arst_n), .start(start), .clear(clear), .shift_en(shift_en),
      .rx_in(rx_in), .data(data_m8), .data_valid(valid[1]), .busy(busy[1]), .bit_cnt(cnt_m8)
`ifdef PARITY_CHK_EN
      , .parity_err(perr[1])
`endif
   );
   sipo_deserializer #(.DATA_W(5), .LSB_FIRST(1'b1), .PARITY_ODD(P_ODD)) u_l5 (
      .clk(clk), .arst_n(arst_n), .start(start), .clear(clear), .shift_en(shift_en),
      .rx_in(rx_in), .data(data_l5), .data_valid(valid[2]), .busy(busy[2]), .bit_cnt(cnt_l5)
`ifdef PARITY_CHK_EN
      , .parity_err(perr[2])
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         mst[k] = 0; mn[k] = 0; mdata[k] = '0; mvalid[k] = 1'b0; mperr[k] = 1'b0;
         prev_valid[k] = 1'b0;
      end
   endfunction

   // Word made from the received bits: first bit at bit 0 or at bit W-1.
   function automatic void model_complete(input int k);
      logic [15:0] w = '0;
      for (int i = 0; i < mw[k]; i++) w[mlsb[k] ? i : mw[k] - 1 - i] = mbits[k][i];
      mdata[k] = w;
      mvalid[k] = 1'b1;
      mst[k] = 0;
      mn[k] = 0;
   endfunction

   function automatic void model_edge(input bit st, input bit cl, input bit se, input bit rx);
      for (int k = 0; k < 3; k++) begin
         mvalid[k] = 1'b0;
         if (cl) begin
            mst[k] = 0; mn[k] = 0;
         end else if (st) begin
            mst[k] = 1; mn[k] = 0;
         end else if (se && mst[k] == 1) begin
            mbits[k][mn[k]] = rx;
            mn[k]++;
            if (mn[k] == mw[k]) begin
`ifdef PARITY_CHK_EN
               mst[k] = 2;
`else
               model_complete(k);
`endif
            end
         end else if (se && mst[k] == 2) begin
            int ones = 0;
            for (int i = 0; i < mw[k]; i++) ones += int'(mbits[k][i]);
            model_complete(k);
            mperr[k] = bit'(ones % 2) ^ rx ^ P_ODD;
         end
      end
   endfunction

   task automatic check_all(input string tag);
      logic [15:0] od;
      logic [3:0]  oc;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin od = {8'h0, data_l8}; oc = cnt_l8; end
            1:       begin od = {8'h0, data_m8}; oc = cnt_m8; end
            default: begin od = {11'h0, data_l5}; oc = {1'b0, cnt_l5}; end
         endcase
         chk($sformatf("%s.data[%0d]", tag, k), 32'(od), 32'(mdata[k]));
         chk($sformatf("%s.valid[%0d]", tag, k), 32'(valid[k]), 32'(mvalid[k]));
         chk($sformatf("%s.busy[%0d]", tag, k), 32'(busy[k]), 32'(mst[k] != 0));
         chk($sformatf("%s.bit_cnt[%0d]", tag, k), 32'(oc), 32'(mn[k]));
         chk($sformatf("%s.no_b2b[%0d]", tag, k), 32'(valid[k] & prev_valid[k]), 32'd0);
`ifdef PARITY_CHK_EN
         chk($sformatf("%s.perr[%0d]", tag, k), 32'(perr[k]), 32'(mperr[k]));
`endif
         prev_valid[k] = valid[k];
      end
      if (valid[0] === 1'b1) vcount_l8++;
   endtask

   task automatic step(input bit st, input bit cl, input bit se, input bit rx);
      start = st; clear = cl; shift_en = se; rx_in = rx;
      @(posedge clk); #1;
      if (arst_n) model_edge(st, cl, se, rx);
      else        model_reset();
      check_all("step");
   endtask

   // Start a frame and send n bits of v (bit 0 first) with random gaps.
   task automatic send_frame(input logic [15:0] v, input int n, input int maxgap);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         int gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
         for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'($urandom));
         step(1'b0, 1'b0, 1'b1, v[i]);
      end
   endtask

   initial begin
      int v0;
      model_reset();
      #2;
      check_all("reset");
      @(negedge clk);
      arst_n = 1'b1;

      // shift_en while idle is ignored
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);

      // 1,0,1,0,0,1,0,1 -> 8'hA5 in both bit orders
      send_frame(16'h00A5, 8, 0);
      chk("a5_lsb", 32'(data_l8), 32'h A5);
      chk("a5_msb", 32'(data_m8), 32'h A5);
`ifndef PARITY_CHK_EN
      chk("a5_valid", 32'(valid[0]), 32'd1);
      chk("a5_busy", 32'(busy[0]), 32'd0);
`endif
      step(1'b0, 1'b1, 1'b0, 1'b0);

      // same frame with random gaps
      send_frame(16'h00A5, 8, 5);
      step(1'b0, 1'b1, 1'b0, 1'b0);

      // restart after 4 bits, then 8'h3C
      v0 = vcount_l8;
      send_frame(16'($urandom), 4, 2);
      send_frame(16'h003C, 8, 1);
`ifdef PARITY_CHK_EN
      step(1'b0, 1'b0, 1'b1, 1'b0);
`endif
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("restart_3c", 32'(data_l8), 32'h3C);
      chk("restart_one_valid", 32'(vcount_l8 - v0), 32'd1);

      // clear + start together mid-frame: idle, count 0, data held
      send_frame(16'h0055, 3, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("clr_start_busy", 32'(busy[0]), 32'd0);

      // start coincident with the final bit discards the frame
      send_frame(16'h00FF, 7, 0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("start_last_cnt", 32'(cnt_l8), 32'd0);
      // clear coincident with a bit
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);

      // 5-bit frame 1,1,0,0,1
      send_frame(16'h0013, 5, 0);
`ifdef PARITY_CHK_EN
      step(1'b0, 1'b0, 1'b1, 1'b1);
`endif
      chk("w5_data", 32'(data_l5), 32'h13);
      chk("w5_cnt", 32'(cnt_l5), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PARITY_CHK_EN
      send_frame(16'h0007, 8, 0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("par_ok_data", 32'(data_l8), 32'h07);
      chk("par_ok", 32'(perr[0]), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(16'h0007, 8, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("par_bad", 32'(perr[0]), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
`endif

      // random traffic
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0),
              1'($urandom), 1'($urandom));

      // asynchronous reset mid-frame after 3 bits
      send_frame(16'h0005, 3, 0);
      #2;
      arst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      step(1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      arst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
